priority_encoder_arb: RTL and testbench
=======================================

PRIORITY_ENCODER_ARB -- requirements
Module: priority_encoder_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is rst_n.
REQ-002 Parameter WIDTH SHALL have default 8 and sets the number of request bits; legal range is 2..64, and values outside it SHALL fail elaboration.
REQ-003 Localparam IDX_W SHALL equal $clog2(WIDTH) and sets the index width; it is not user-settable.
REQ-004 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that in_data holds a request vector.
REQ-007 in_ready  output  1  SHALL indicate that the block can accept a vector.
REQ-008 in_data  input  WIDTH  SHALL be the request vector; bit WIDTH-1 is the highest fixed priority.
REQ-009 out_valid  output  1  SHALL indicate that the out_* fields hold a beat.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the beat.
REQ-011 out_idx  output  IDX_W  SHALL be the index of the set bit currently being reported.
REQ-012 out_none  output  1  SHALL be high when the accepted vector was all zeros.
REQ-013 out_last  output  1  SHALL mark the final beat for the accepted vector.

Function
REQ-014 States SHALL be IDLE and DRAIN; in_ready=1 only in IDLE; out_valid=1 only in DRAIN.
REQ-015 An input handshake (in_valid & in_ready) SHALL load in_data into a WIDTH-bit pending register P and move the state to DRAIN on the same edge.
REQ-016 First beat latency SHALL be 1 cycle: out_valid is high in the cycle after the input handshake.
REQ-017 In DRAIN, out_idx SHALL be the first set bit of P in search order (REQ-024/025); out_idx, out_none and out_last SHALL be decoded from registers only, with no combinational path from any input.
REQ-018 out_last SHALL be 1 when P has exactly one set bit, or when out_none=1.
REQ-019 On an output handshake (out_valid & out_ready), the reported bit SHALL be cleared from P; if out_last=1, the state SHALL return to IDLE.
REQ-020 With out_ready held high, a vector with k set bits SHALL produce k beats on k consecutive cycles; in_ready SHALL return high in the cycle after the last beat.
REQ-021 An all-zero vector SHALL produce exactly one beat with out_none=1, out_idx=0 and out_last=1.
REQ-022 While out_ready=0, out_idx, out_none and out_last SHALL hold stable, and out_valid SHALL stay high.
REQ-023 in_valid and in_data SHALL be ignored while in DRAIN, including in the cycle of the last output handshake.

Reset
REQ-026 While rst_n=0, regardless of clk: the state SHALL be IDLE, P=0, the rotation pointer (if present) SHALL be WIDTH-1, out_valid=0, in_ready=1, out_idx=0, out_none=0 and out_last=0.
REQ-027 Reset asserted mid-drain SHALL discard the remaining beats; the first input handshake after release SHALL behave as after power-up.

Configuration
REQ-024 Without PRIO_ENC_ROUND_ROBIN_EN, the search SHALL descend from bit WIDTH-1 to bit 0, giving fixed MSB-first priority.
REQ-025 With PRIO_ENC_ROUND_ROBIN_EN defined, an IDX_W-bit pointer PTR SHALL be added.
- The search starts at PTR and descends, wrapping from 0 to WIDTH-1.
- After each output handshake reporting index i with out_none=0, PTR SHALL become (i-1) mod WIDTH.
- PTR SHALL persist across vectors.
- An out_none beat SHALL leave PTR unchanged.
REQ-028 The macro SHALL NOT change any port or handshake timing; only the reporting order changes.

Verification
REQ-029 WIDTH=8, in_data=0x85, out_ready=1 -> beats idx 7,2,0 on three consecutive cycles starting the cycle after accept; out_last=1 only on idx 0; in_ready=0 across all three beats.
REQ-030 in_data=0x00 -> exactly one beat with out_none=1, out_idx=0, out_last=1; in_ready=1 the next cycle.
REQ-031 in_data=0x90, out_ready=0 for 3 cycles then 1 -> out_idx=7 held for 4 cycles, then idx 4 with out_last=1.
REQ-032 in_data=0x84 then 0x0A, out_ready=1 -> without macro: 7,2,3,1; with PRIO_ENC_ROUND_ROBIN_EN: 7,2,1,3 (PTR=1 after the first vector).
REQ-033 in_data=0xFF, rst_n pulsed low after 2 beats -> out_valid=0 immediately without a clock edge, then in_ready=1; after release, in_data=0x03 -> beats 1,0 in both builds (PTR reset to 7).
REQ-034 in_valid held high with 0x01 throughout a 0xC0 drain -> beats 7,6 only; 0x01 accepted in the cycle after idx 6, giving beat 0 one cycle later.

Source files
------------

// File: rtl/priority_encoder_arb.sv
// -----------------------------------------------------------------------------
// priority_encoder_arb
//
// Accepts a WIDTH-bit request vector, then reports every set bit as one output
// beat (index per beat), in priority search order. An all-zero vector yields a
// single "none" beat. The block is single-buffered: it accepts a new vector only
// once the previous one has been fully drained.
//
// Optional feature macro: PRIO_ENC_ROUND_ROBIN_EN
//   undefined : fixed priority, search descends from bit WIDTH-1 to bit 0.
//   defined   : a persistent pointer sets the search start; after reporting
//               index i the pointer moves to (i-1) mod WIDTH, so the search
//               resumes just below the last granted bit and wraps 0 -> WIDTH-1.
//   Ports and handshake timing are identical in both builds.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data holds a request vector
//   in_ready   out  block is IDLE and can accept a vector
//   in_data    in   request vector, bit WIDTH-1 = highest fixed priority
//   out_valid  out  out_* fields hold a beat (block is draining)
//   out_ready  in   consumer accepts the beat
//   out_idx    out  index of the set bit being reported
//   out_none   out  accepted vector was all zeros
//   out_last   out  final beat for the accepted vector
// -----------------------------------------------------------------------------
module priority_encoder_arb #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_last
);

  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("priority_encoder_arb: WIDTH must be in the range 2..64");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] hit_idx;
  logic             draining;
  logic             pend_zero;
  logic             pend_single;
  logic             in_hs;
  logic             out_hs;

  // First set bit of vec, searching downward from start and wrapping from
  // bit 0 to bit WIDTH-1. Returns 0 when vec is all zeros.
  function automatic logic [IDX_W-1:0] find_first(input logic [WIDTH-1:0] vec,
                                                  input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] res;
    logic             found;
    int               pos;
    res   = '0;
    found = 1'b0;
    for (int off = 0; off < WIDTH; off++) begin
      pos = int'(start) - off;
      if (pos < 0) pos = pos + WIDTH;
      if (!found && vec[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        res   = IDX_W'(pos);
      end
    end
    return res;
  endfunction

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  // A "none" beat reports no bit, so the pointer only moves on real grants.
  always_comb begin
    ptr_d = ptr_q;
    if (out_hs && !pend_zero) begin
      ptr_d = (hit_idx == '0) ? IDX_W'(WIDTH - 1) : hit_idx - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(WIDTH - 1);
    else        ptr_q <= ptr_d;
  end
`else
  assign start_idx = IDX_W'(WIDTH - 1);
`endif

  // All output fields are decoded from state_q / pend_q (and ptr_q) only, so
  // nothing on the input side reaches them combinationally. Gating with
  // draining keeps them at zero while idle and during reset.
  assign draining    = (state_q == DRAIN);
  assign pend_zero   = (pend_q == '0);
  assign pend_single = !pend_zero && ((pend_q & (pend_q - WIDTH'(1))) == '0);
  assign hit_idx     = find_first(pend_q, start_idx);

  assign in_ready  = !draining;
  assign out_valid = draining;
  assign out_idx   = draining ? hit_idx : '0;
  assign out_none  = draining && pend_zero;
  assign out_last  = draining && (pend_zero || pend_single);

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // in_hs and out_hs are mutually exclusive (IDLE vs DRAIN), so input traffic
  // during the final output handshake is ignored by construction.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (in_hs) begin
      pend_d  = in_data;
      state_d = DRAIN;
    end else if (out_hs) begin
      pend_d[hit_idx] = 1'b0;
      if (out_last) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder_arb.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_arb
//
// Bench for priority_encoder_arb (WIDTH=8). A queue-based reference model turns
// each accepted vector into its list of expected beats; the DUT outputs are
// compared against the model every cycle, and directed scenarios also compare
// the sequence of handshaked indices against fixed expected lists.
// Compile with +define+PRIO_ENC_ROUND_ROBIN_EN to exercise the rotating build.
// -----------------------------------------------------------------------------
module tb_priority_encoder_arb;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_none;
  logic          out_last;

  priority_encoder_arb #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_none  (out_none),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_busy;
  bit m_none;
  int m_ptr;
  int beat_q[$];

  // Indices seen on DUT output handshakes
  int dut_log[$];
  int exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_none = 1'b0;
    m_ptr  = W - 1;
    beat_q.delete();
  endtask

  // Beats of a vector: set bits ordered by downward distance from the search
  // start. A whole drain is one wrapped descending sweep, because the pointer
  // always lands just below the bit it just reported.
  task automatic model_load(input logic [W-1:0] v);
    m_busy = 1'b1;
    m_none = (v == '0);
    beat_q.delete();
    if (m_none) beat_q.push_back(0);
    else begin
      for (int k = 0; k < W; k++) begin
        int i;
        i = ((RR ? m_ptr : W - 1) - k + W) % W;
        if (v[i]) beat_q.push_back(i);
      end
    end
  endtask

  task automatic model_update(input logic iv, input logic [W-1:0] id, input logic ordy);
    if (!m_busy) begin
      if (iv) model_load(id);
    end else if (ordy) begin
      if (RR && !m_none) m_ptr = (beat_q[0] + W - 1) % W;
      void'(beat_q.pop_front());
      if (beat_q.size() == 0) m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("in_ready",  in_ready,  !m_busy);
    check_eq("out_valid", out_valid, m_busy);
    check_eq("out_idx",   out_idx,   m_busy ? beat_q[0] : 0);
    check_eq("out_none",  out_none,  m_busy && m_none);
    check_eq("out_last",  out_last,  m_busy && (beat_q.size() == 1));
  endtask

  // Called just after a falling edge: drive inputs, log a pending output
  // handshake, advance one rising edge, then check at the next falling edge.
  task automatic tick(input logic iv, input logic [W-1:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    if (out_valid && ordy) dut_log.push_back(int'(out_idx));
    @(posedge clk);
    model_update(iv, id, ordy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_log(input string tag, input int exp[$]);
    check_eq({tag, "_nbeats"}, dut_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), dut_log[i], exp[i]);
    dut_log.delete();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_rst_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_rst_in_ready"},  in_ready,  1'b1);
    check_eq({tag, "_rst_out_idx"},   out_idx,   0);
    check_eq({tag, "_rst_out_none"},  out_none,  1'b0);
    check_eq({tag, "_rst_out_last"},  out_last,  1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dut_log.delete();
  endtask

  task automatic go_idle();
    int n;
    n = 0;
    while (!in_ready && n < 4 * W) begin
      tick(1'b0, '0, 1'b1);
      n++;
    end
    check_eq("go_idle_in_ready", in_ready, 1'b1);
    dut_log.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset values while held in reset, before any clock edge
    #2;
    check_eq("por_in_ready",  in_ready,  1'b1);
    check_eq("por_out_valid", out_valid, 1'b0);
    check_eq("por_out_idx",   out_idx,   0);
    check_eq("por_out_none",  out_none,  1'b0);
    check_eq("por_out_last",  out_last,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x85 -> 7,2,0 back to back
    tick(1'b1, 8'h85, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    exp_q = {7, 2, 0};
    check_log("r029", exp_q);

    // All-zero vector -> one none beat
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b0, '0, 1'b1);
    exp_q = {0};
    check_log("r030", exp_q);

    // Backpressure: 0x90 with out_ready low for 3 valid cycles
    tick(1'b1, 8'h90, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    exp_q = {7, 4};
    check_log("r031", exp_q);

    // Two vectors back to back, from a fresh pointer
    do_reset("r032");
    tick(1'b1, 8'h84, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 8'h0A, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    if (RR) exp_q = {7, 2, 1, 3};
    else    exp_q = {7, 2, 3, 1};
    check_log("r032", exp_q);

    // in_valid held with 0x01 throughout a 0xC0 drain
    go_idle();
    tick(1'b1, 8'hC0, 1'b1);
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b0, '0, 1'b1);
    exp_q = {7, 6, 0};
    check_log("r034", exp_q);

    // Reset mid-drain of 0xFF, then 0x03 behaves as after power-up
    go_idle();
    tick(1'b1, 8'hFF, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    do_reset("r033");
    check_outputs();
    tick(1'b1, 8'h03, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    exp_q = {1, 0};
    check_log("r033", exp_q);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] d;
      int           sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      d = '0;
      else if (sel <= 2) d = W'(1) << $urandom_range(0, W - 1);
      else               d = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand");
        check_outputs();
      end else begin
        tick($urandom_range(0, 1) == 1, d, $urandom_range(0, 9) < 7);
      end
    end
    dut_log.delete();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
